// File: rtl/rmap_wb_pkg.sv
// Shared types and helpers for the RMAP-to-Wishbone byte-stream master.
// Lanes are big-endian: lane 0 is bits 31:24 and wb_sel[3].
package rmap_wb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FILL,
      ST_BUS,
      ST_DRAIN,
      ST_DONE
   } state_e;

   localparam logic [1:0] STATUS_OK      = 2'b00;
   localparam logic [1:0] STATUS_BUS_ERR = 2'b01;
   localparam logic [1:0] STATUS_TIMEOUT = 2'b10;

   localparam int BYTES_PER_WORD = 4;

   function automatic logic [31:0] put_byte(input logic [31:0] word,
                                            input logic [1:0]  lane,
                                            input logic [7:0]  b);
      logic [31:0] w;
      w = word;
      case (lane)
         2'd0:    w[31:24] = b;
         2'd1:    w[23:16] = b;
         2'd2:    w[15:8]  = b;
         default: w[7:0]   = b;
      endcase
      return w;
   endfunction

   function automatic logic [7:0] get_byte(input logic [31:0] word,
                                           input logic [1:0]  lane);
      logic [7:0] b;
      case (lane)
         2'd0:    b = word[31:24];
         2'd1:    b = word[23:16];
         2'd2:    b = word[15:8];
         default: b = word[7:0];
      endcase
      return b;
   endfunction

   function automatic logic [3:0] lane_bit(input logic [1:0] lane);
      return 4'b1000 >> lane;
   endfunction

endpackage

// File: rtl/rmap_wb_lane_ctrl.sv
// Byte-lane window for one word: selects lanes from lane_i up to lane 3 or the
// last remaining byte, and flags when lane_i is the final byte of the word.
module rmap_wb_lane_ctrl
   import rmap_wb_pkg::*;
(
   input  logic [1:0]  lane_i,
   input  logic [23:0] rem_i,
   output logic [3:0]  sel_o,
   output logic        eow_o
);

   logic [2:0] span;
   logic [1:0] last_lane;

   always_comb begin
      span = 3'(BYTES_PER_WORD) - {1'b0, lane_i};
      if (rem_i >= {21'd0, span}) begin
         last_lane = 2'd3;
      end else begin
         last_lane = lane_i + rem_i[1:0] - 2'd1;
      end
      if (rem_i == 24'd0) begin
         sel_o = 4'd0;
      end else begin
         sel_o = (4'hF >> lane_i) & (4'hF << (2'd3 - last_lane));
      end
      eow_o = (lane_i == 2'd3) || (rem_i <= 24'd1);
   end

endmodule

// File: rtl/rmap_wb_master.sv
// Byte-stream command to Wishbone master, one word access per bus cycle.
// Optional bus watchdog enabled by defining RMAP_WB_TIMEOUT_EN.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | cmd_ready high, waiting for a command
// ST_FILL  | collecting write bytes into wb_dat_o (or discarding after abort)
// ST_BUS   | wb_cyc/wb_stb asserted, waiting for ack/err/timeout
// ST_DRAIN | streaming the selected lanes of the read word out on rd_data
// ST_DONE  | one-cycle done pulse with status
module rmap_wb_master
   import rmap_wb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic        cmd_inc,
   input  logic [31:0] cmd_adr,
   input  logic [23:0] cmd_len,
   input  logic        wr_valid,
   output logic        wr_ready,
   input  logic [7:0]  wr_data,
   output logic        rd_valid,
   input  logic        rd_ready,
   output logic [7:0]  rd_data,
   output logic        done,
   output logic [1:0]  status,
   output logic        wb_cyc,
   output logic        wb_stb,
   output logic        wb_we,
   output logic [31:0] wb_adr,
   output logic [3:0]  wb_sel,
   output logic [31:0] wb_dat_o,
   input  logic [31:0] wb_dat_i,
   input  logic        wb_ack,
   input  logic        wb_err
);

   if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 256)) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must fit the 8-bit watchdog (1..256)");
   end

   state_e      state_q, state_d;
   logic [23:0] rem_q, rem_d, rem_dec;
   logic [1:0]  lane_q, lane_d, base_lane_q, base_lane_d, next_start;
   logic        inc_q, inc_d, write_q, write_d, abort_q, abort_d;
   logic [31:0] rdat_q, rdat_d;
   logic        cmd_ready_q, cmd_ready_d, wr_ready_q, wr_ready_d;
   logic        rd_valid_q, rd_valid_d, done_q, done_d;
   logic [1:0]  status_q, status_d;
   logic        wb_cyc_q, wb_cyc_d, wb_we_q, wb_we_d;
   logic [31:0] wb_adr_q, wb_adr_d, wb_dat_o_q, wb_dat_o_d;
   logic [3:0]  wb_sel_q, wb_sel_d;
   logic [1:0]  lc_lane;
   logic [23:0] lc_rem;
   logic [3:0]  lc_sel;
   logic        lc_eow, drain_eow, tmo_hit;

   assign rem_dec    = (rem_q == 24'd0) ? 24'd0 : rem_q - 24'd1;
   assign next_start = inc_q ? 2'd0 : base_lane_q;
   assign drain_eow  = ((wb_sel_q & (4'b0111 >> lane_q)) == 4'd0);

   // IDLE and DRAIN look ahead to the window of the word about to go on the bus.
   always_comb begin
      lc_lane = lane_q;
      lc_rem  = rem_q;
      if (state_q == ST_IDLE) begin
         lc_lane = cmd_adr[1:0];
         lc_rem  = cmd_len;
      end else if (state_q == ST_DRAIN) begin
         lc_lane = next_start;
         lc_rem  = rem_dec;
      end
   end

   rmap_wb_lane_ctrl u_lane_ctrl (
      .lane_i (lc_lane),
      .rem_i  (lc_rem),
      .sel_o  (lc_sel),
      .eow_o  (lc_eow)
   );

`ifdef RMAP_WB_TIMEOUT_EN
   localparam logic [7:0] TMO_LOAD = 8'(TIMEOUT_CYCLES - 1);
   logic [7:0] tmo_q, tmo_d;

   assign tmo_d   = wb_cyc_q ? tmo_q - 8'd1 : TMO_LOAD;
   assign tmo_hit = wb_cyc_q && (tmo_q == 8'd0);

   always_ff @(posedge clk) begin
      if (!rst_n) tmo_q <= TMO_LOAD;
      else        tmo_q <= tmo_d;
   end
`else
   assign tmo_hit = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      rem_d       = rem_q;
      lane_d      = lane_q;
      base_lane_d = base_lane_q;
      inc_d       = inc_q;
      write_d     = write_q;
      abort_d     = abort_q;
      rdat_d      = rdat_q;
      cmd_ready_d = cmd_ready_q;
      wr_ready_d  = wr_ready_q;
      rd_valid_d  = rd_valid_q;
      done_d      = 1'b0;
      status_d    = status_q;
      wb_cyc_d    = wb_cyc_q;
      wb_we_d     = wb_we_q;
      wb_adr_d    = wb_adr_q;
      wb_sel_d    = wb_sel_q;
      wb_dat_o_d  = wb_dat_o_q;

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               base_lane_d = cmd_adr[1:0];
               lane_d      = cmd_adr[1:0];
               rem_d       = cmd_len;
               inc_d       = cmd_inc;
               write_d     = cmd_write;
               abort_d     = 1'b0;
               status_d    = STATUS_OK;
               wb_adr_d    = {cmd_adr[31:2], 2'b00};
               cmd_ready_d = 1'b0;
               if (cmd_len == 24'd0) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else if (cmd_write) begin
                  state_d    = ST_FILL;
                  wr_ready_d = 1'b1;
                  wb_sel_d   = 4'd0;
                  wb_dat_o_d = 32'd0;
               end else begin
                  state_d  = ST_BUS;
                  wb_cyc_d = 1'b1;
                  wb_we_d  = 1'b0;
                  wb_sel_d = lc_sel;
               end
            end
         end
         ST_FILL: begin
            if (wr_valid) begin
               rem_d  = rem_dec;
               lane_d = lane_q + 2'd1;
               if (abort_q) begin
                  if (rem_q <= 24'd1) begin
                     state_d    = ST_DONE;
                     done_d     = 1'b1;
                     wr_ready_d = 1'b0;
                  end
               end else begin
                  wb_dat_o_d = put_byte(wb_dat_o_q, lane_q, wr_data);
                  wb_sel_d   = wb_sel_q | lane_bit(lane_q);
                  if (lc_eow) begin
                     state_d    = ST_BUS;
                     wr_ready_d = 1'b0;
                     wb_cyc_d   = 1'b1;
                     wb_we_d    = 1'b1;
                  end
               end
            end
         end
         ST_BUS: begin
            // err wins over a simultaneous ack; remaining write bytes are still drained
            if (wb_err || tmo_hit) begin
               wb_cyc_d = 1'b0;
               wb_we_d  = 1'b0;
               status_d = wb_err ? STATUS_BUS_ERR : STATUS_TIMEOUT;
               if (write_q && (rem_q != 24'd0)) begin
                  state_d    = ST_FILL;
                  abort_d    = 1'b1;
                  wr_ready_d = 1'b1;
               end else begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end
            end else if (wb_ack) begin
               wb_cyc_d = 1'b0;
               wb_we_d  = 1'b0;
               if (inc_q) wb_adr_d = wb_adr_q + 32'd4;
               if (write_q) begin
                  lane_d = next_start;
                  if (rem_q != 24'd0) begin
                     state_d    = ST_FILL;
                     wr_ready_d = 1'b1;
                     wb_sel_d   = 4'd0;
                     wb_dat_o_d = 32'd0;
                  end else begin
                     state_d = ST_DONE;
                     done_d  = 1'b1;
                  end
               end else begin
                  rdat_d     = wb_dat_i;
                  state_d    = ST_DRAIN;
                  rd_valid_d = 1'b1;
               end
            end
         end
         ST_DRAIN: begin
            if (rd_ready) begin
               rem_d  = rem_dec;
               lane_d = lane_q + 2'd1;
               if (drain_eow) begin
                  rd_valid_d = 1'b0;
                  if (rem_q <= 24'd1) begin
                     state_d = ST_DONE;
                     done_d  = 1'b1;
                  end else begin
                     state_d  = ST_BUS;
                     wb_cyc_d = 1'b1;
                     wb_sel_d = lc_sel;
                     lane_d   = next_start;
                  end
               end
            end
         end
         ST_DONE: begin
            state_d     = ST_IDLE;
            cmd_ready_d = 1'b1;
         end
         default: begin
            state_d     = ST_IDLE;
            cmd_ready_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         rem_q       <= 24'd0;
         lane_q      <= 2'd0;
         base_lane_q <= 2'd0;
         inc_q       <= 1'b0;
         write_q     <= 1'b0;
         abort_q     <= 1'b0;
         rdat_q      <= 32'd0;
         cmd_ready_q <= 1'b1;
         wr_ready_q  <= 1'b0;
         rd_valid_q  <= 1'b0;
         done_q      <= 1'b0;
         status_q    <= STATUS_OK;
         wb_cyc_q    <= 1'b0;
         wb_we_q     <= 1'b0;
         wb_adr_q    <= 32'd0;
         wb_sel_q    <= 4'd0;
         wb_dat_o_q  <= 32'd0;
      end else begin
         state_q     <= state_d;
         rem_q       <= rem_d;
         lane_q      <= lane_d;
         base_lane_q <= base_lane_d;
         inc_q       <= inc_d;
         write_q     <= write_d;
         abort_q     <= abort_d;
         rdat_q      <= rdat_d;
         cmd_ready_q <= cmd_ready_d;
         wr_ready_q  <= wr_ready_d;
         rd_valid_q  <= rd_valid_d;
         done_q      <= done_d;
         status_q    <= status_d;
         wb_cyc_q    <= wb_cyc_d;
         wb_we_q     <= wb_we_d;
         wb_adr_q    <= wb_adr_d;
         wb_sel_q    <= wb_sel_d;
         wb_dat_o_q  <= wb_dat_o_d;
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign wr_ready  = wr_ready_q;
   assign rd_valid  = rd_valid_q;
   assign rd_data   = get_byte(rdat_q, lane_q);
   assign done      = done_q;
   assign status    = status_q;
   assign wb_cyc    = wb_cyc_q;
   assign wb_stb    = wb_cyc_q;
   assign wb_we     = wb_we_q;
   assign wb_adr    = wb_adr_q;
   assign wb_sel    = wb_sel_q;
   assign wb_dat_o  = wb_dat_o_q;

endmodule

// File: tb/tb_rmap_wb_master.sv
// Directed bench for rmap_wb_master with a behavioural Wishbone slave.
// Build with RMAP_WB_TIMEOUT_EN to exercise the watchdog path.
module tb_rmap_wb_master;

   logic        clk, rst_n;
   logic        cmd_valid, cmd_ready, cmd_write, cmd_inc;
   logic [31:0] cmd_adr;
   logic [23:0] cmd_len;
   logic        wr_valid, wr_ready;
   logic [7:0]  wr_data;
   logic        rd_valid, rd_ready;
   logic [7:0]  rd_data;
   logic        done;
   logic [1:0]  status;
   logic        wb_cyc, wb_stb, wb_we;
   logic [31:0] wb_adr, wb_dat_o, wb_dat_i;
   logic [3:0]  wb_sel;
   logic        wb_ack, wb_err;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0]  wbytes [0:15];
   logic [7:0]  rbytes [0:15];
   logic [31:0] log_adr [0:15];
   logic [31:0] log_dat [0:15];
   logic [3:0]  log_sel [0:15];
   logic        log_we  [0:15];
   logic [31:0] rd_words [$];
   int          widx, ridx, n_log, cyc_cnt, stb_cnt, hold_bad;
   int          slv_mode;    // 0 ack, 1 ack+err, 2 silent
   logic [1:0]  got_status;
   bit          got_done;

   rmap_wb_master #(.TIMEOUT_CYCLES(10)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_inc(cmd_inc), .cmd_adr(cmd_adr), .cmd_len(cmd_len),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
      .done(done), .status(status),
      .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
      .wb_sel(wb_sel), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
      .wb_ack(wb_ack), .wb_err(wb_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // zero-wait slave: answers at the negedge after stb is seen
   initial begin
      wb_ack = 1'b0; wb_err = 1'b0; wb_dat_i = 32'd0;
      forever begin
         @(negedge clk);
         wb_ack = 1'b0;
         wb_err = 1'b0;
         if (wb_cyc) cyc_cnt++;
         if (wb_cyc && wb_stb) begin
            stb_cnt++;
            if (slv_mode != 2) begin
               if (n_log < 16) begin
                  log_adr[n_log] = wb_adr;
                  log_dat[n_log] = wb_dat_o;
                  log_sel[n_log] = wb_sel;
                  log_we[n_log]  = wb_we;
               end
               n_log++;
               wb_ack = 1'b1;
               if (slv_mode == 1) wb_err = 1'b1;
               if (rd_words.size() > 0) wb_dat_i = rd_words.pop_front();
               else                     wb_dat_i = 32'd0;
            end
         end
      end
   end

   task automatic run_cmd(input logic wr, input logic inc, input logic [31:0] adr,
                          input logic [23:0] len, input int budget, input bit stall);
      bit         prev_hold;
      logic [7:0] prev_data;
      widx = 0; ridx = 0; n_log = 0; cyc_cnt = 0; stb_cnt = 0; hold_bad = 0;
      got_done = 1'b0; prev_hold = 1'b0; prev_data = 8'd0;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_write = wr; cmd_inc = inc; cmd_adr = adr; cmd_len = len;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         cmd_valid = 1'b0;
         if (prev_hold && (!rd_valid || (rd_data !== prev_data))) hold_bad++;
         if (done) begin
            got_status = status;
            got_done   = 1'b1;
            break;
         end
         wr_valid = (widx < int'(len));
         if (widx < 16) wr_data = wbytes[widx];
         if (wr_valid && wr_ready) widx++;
         rd_ready  = stall ? ((k % 2) == 1) : 1'b1;
         prev_hold = rd_valid && !rd_ready;
         prev_data = rd_data;
         if (rd_valid && rd_ready) begin
            if (ridx < 16) rbytes[ridx] = rd_data;
            ridx++;
         end
      end
      wr_valid = 1'b0;
      rd_ready = 1'b0;
   endtask

   task automatic after_done(input string tag);
      @(negedge clk);
      check_eq({tag, "_done_low"}, {31'd0, done}, 32'd0);
      check_eq({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
   endtask

   initial begin
      bit seen_done;
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_inc = 1'b0;
      cmd_adr = 32'd0; cmd_len = 24'd0; wr_valid = 1'b0; wr_data = 8'd0;
      rd_ready = 1'b0; slv_mode = 0;
      repeat (3) @(negedge clk);
      check_eq("rst_bus", {wb_cyc, wb_stb, wb_we, wb_sel}, 32'd0);
      check_eq("rst_adr", wb_adr, 32'd0);
      check_eq("rst_dat", wb_dat_o, 32'd0);
      check_eq("rst_flags", {rd_valid, wr_ready, done, status}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

      // aligned incrementing write
      for (int i = 0; i < 16; i++) wbytes[i] = 8'(8'h11 + i);
      run_cmd(1'b1, 1'b1, 32'h100, 24'd8, 60, 1'b0);
      check_eq("wr_done", {31'd0, got_done}, 32'd1);
      check_eq("wr_status", {30'd0, got_status}, 32'd0);
      check_eq("wr_ncyc", n_log, 2);
      check_eq("wr_adr0", log_adr[0], 32'h100);
      check_eq("wr_adr1", log_adr[1], 32'h104);
      check_eq("wr_sel", {log_sel[0], log_sel[1]}, 32'hFF);
      check_eq("wr_dat0", log_dat[0], 32'h11121314);
      check_eq("wr_dat1", log_dat[1], 32'h15161718);
      check_eq("wr_we", {log_we[0], log_we[1]}, 32'd3);
      check_eq("wr_consumed", widx, 8);
      after_done("wr");

      // unaligned read with rd_ready stalls
      rd_words.push_back(32'hAABBCCDD);
      rd_words.push_back(32'h01020304);
      run_cmd(1'b0, 1'b1, 32'h203, 24'd3, 60, 1'b1);
      check_eq("rd_done", {31'd0, got_done}, 32'd1);
      check_eq("rd_status", {30'd0, got_status}, 32'd0);
      check_eq("rd_ncyc", n_log, 2);
      check_eq("rd_adr0", log_adr[0], 32'h200);
      check_eq("rd_adr1", log_adr[1], 32'h204);
      check_eq("rd_sel0", {28'd0, log_sel[0]}, 32'h1);
      check_eq("rd_sel1", {28'd0, log_sel[1]}, 32'hC);
      check_eq("rd_we", {log_we[0], log_we[1]}, 32'd0);
      check_eq("rd_nbytes", ridx, 3);
      check_eq("rd_bytes", {rbytes[0], rbytes[1], rbytes[2]}, 32'hDD0102);
      check_eq("rd_hold", hold_bad, 0);
      after_done("rd");

      // non-incrementing write
      for (int i = 0; i < 16; i++) wbytes[i] = 8'(8'h21 + i);
      run_cmd(1'b1, 1'b0, 32'h40, 24'd8, 60, 1'b0);
      check_eq("ni_status", {30'd0, got_status}, 32'd0);
      check_eq("ni_ncyc", n_log, 2);
      check_eq("ni_adr0", log_adr[0], 32'h40);
      check_eq("ni_adr1", log_adr[1], 32'h40);
      check_eq("ni_sel", {log_sel[0], log_sel[1]}, 32'hFF);
      check_eq("ni_dat1", log_dat[1], 32'h25262728);

      // ack+err together on the first access of a write
      for (int i = 0; i < 16; i++) wbytes[i] = 8'(8'h31 + i);
      slv_mode = 1;
      run_cmd(1'b1, 1'b1, 32'h300, 24'd8, 60, 1'b0);
      check_eq("err_done", {31'd0, got_done}, 32'd1);
      check_eq("err_status", {30'd0, got_status}, 32'd1);
      check_eq("err_ncyc", n_log, 1);
      check_eq("err_consumed", widx, 8);
      check_eq("err_dat0", log_dat[0], 32'h31323334);
      after_done("err");

      // bus error on a read: no rd beats
      run_cmd(1'b0, 1'b1, 32'h500, 24'd8, 60, 1'b0);
      check_eq("rerr_status", {30'd0, got_status}, 32'd1);
      check_eq("rerr_ncyc", n_log, 1);
      check_eq("rerr_nbytes", ridx, 0);
      slv_mode = 0;

      // zero-length command
      run_cmd(1'b1, 1'b1, 32'h600, 24'd0, 20, 1'b0);
      check_eq("len0_done", {31'd0, got_done}, 32'd1);
      check_eq("len0_status", {30'd0, got_status}, 32'd0);
      check_eq("len0_cyc", cyc_cnt, 0);
      after_done("len0");

      // two middle lanes only; unselected lanes must be zero
      wbytes[0] = 8'hAA; wbytes[1] = 8'hBB;
      run_cmd(1'b1, 1'b1, 32'h101, 24'd2, 40, 1'b0);
      check_eq("mid_ncyc", n_log, 1);
      check_eq("mid_adr", log_adr[0], 32'h100);
      check_eq("mid_sel", {28'd0, log_sel[0]}, 32'h6);
      check_eq("mid_dat", log_dat[0], 32'h00AABB00);

      // non-incrementing unaligned read restarts at lane 2
      rd_words.push_back(32'h11223344);
      rd_words.push_back(32'h55667788);
      run_cmd(1'b0, 1'b0, 32'h42, 24'd4, 60, 1'b0);
      check_eq("nir_ncyc", n_log, 2);
      check_eq("nir_adr", {log_adr[0][15:0], log_adr[1][15:0]}, 32'h00400040);
      check_eq("nir_sel", {log_sel[0], log_sel[1]}, 32'h33);
      check_eq("nir_bytes", {rbytes[0], rbytes[1], rbytes[2], rbytes[3]}, 32'h33447788);

      slv_mode = 2;
`ifdef RMAP_WB_TIMEOUT_EN
      run_cmd(1'b0, 1'b1, 32'h700, 24'd4, 60, 1'b0);
      check_eq("tmo_done", {31'd0, got_done}, 32'd1);
      check_eq("tmo_status", {30'd0, got_status}, 32'd2);
      check_eq("tmo_stb_cycles", stb_cnt, 10);
      run_cmd(1'b0, 1'b1, 32'h700, 24'd4, 6, 1'b0);
`else
      run_cmd(1'b0, 1'b1, 32'h700, 24'd4, 300, 1'b0);
      check_eq("wait_no_done", {31'd0, got_done}, 32'd0);
`endif
      check_eq("pre_rst_stb", {31'd0, wb_stb}, 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      check_eq("bus_rst_cyc", {wb_cyc, wb_stb}, 32'd0);
      check_eq("bus_rst_done", {31'd0, done}, 32'd0);
      rst_n = 1'b1;
      seen_done = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (done) seen_done = 1'b1;
      end
      check_eq("bus_rst_no_done", {31'd0, seen_done}, 32'd0);
      check_eq("bus_rst_ready", {31'd0, cmd_ready}, 32'd1);
      slv_mode = 0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
